// File: rtl/io_defs_pkg.sv
// ============================================================================
// io_defs: bus addresses, CTRL bit positions and helpers shared by the I/O devices.
// Revision: 1.0
// ============================================================================
`default_nettype none

package io_defs;

  localparam logic [31:0] KEY_DATA_ADDR = 32'hF000_0010;
  localparam logic [31:0] KEY_CTRL_ADDR = 32'hF000_0110;
  localparam logic [31:0] SW_DATA_ADDR  = 32'hF000_0014;
  localparam logic [31:0] SW_CTRL_ADDR  = 32'hF000_0114;

  localparam int CTRL_READY   = 0;
  localparam int CTRL_OVERRUN = 2;
  localparam int CTRL_IE      = 8;

  localparam logic [31:0] BUS_DEFAULT = 32'hDEAD_BEEF;

  function automatic logic [31:0] ctrl_word(input logic ie, input logic ovr, input logic rdy);
    logic [31:0] w;
    w               = '0;
    w[CTRL_IE]      = ie;
    w[CTRL_OVERRUN] = ovr;
    w[CTRL_READY]   = rdy;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/io_debouncer.sv
// ============================================================================
// io_debouncer: 2-flop synchronizer plus stable-run counter; emits a one-cycle
// event when the debounced value is updated.  Revision: 1.0
// ============================================================================
`default_nettype none

module io_debouncer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] db_o,
  output logic             event_o
);

  localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [WIDTH-1:0] sync1_q, sync2_q, prev_q, db_q, db_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // cnt_d = number of consecutive cycles, including this one, that sync2_q has held its value
  always_comb begin
    if (sync2_q != prev_q) begin
      cnt_d = CW'(1);
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    event_o = (sync2_q != db_q) && (cnt_d == CNT_MAX);
    db_d    = event_o ? sync2_q : db_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      db_q    <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign db_o = db_q;

endmodule

`default_nettype wire

// File: rtl/io_input_ctrl.sv
// ============================================================================
// io_input_ctrl: memory-mapped KEY/SW input registers with status, interrupt
// enable and registered IRQ.  Revision: 1.0
// ============================================================================
`default_nettype none

module io_input_ctrl
  import io_defs::*;
#(
  parameter logic [31:0] ADDRKEY         = KEY_DATA_ADDR,
  parameter logic [31:0] ADDRKCTRL       = KEY_CTRL_ADDR,
  parameter logic [31:0] ADDRSW          = SW_DATA_ADDR,
  parameter logic [31:0] ADDRSCTRL       = SW_CTRL_ADDR,
  parameter int          DEBOUNCE_CYCLES = 500000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  KEY,
  input  logic [9:0]  SW,
  input  logic [31:0] ADDRIN,
  input  logic [31:0] DIN,
  input  logic        WE,
  input  logic        RE,
  output logic [31:0] DOUT,
  output logic        SEL,
  output logic        IRQ
);

  logic [3:0] key_n, key_db;
  logic [9:0] sw_db;
  logic       key_ev, sw_ev;

  // Buttons are active-low; invert so a released key reads as 0
  assign key_n = ~KEY;

  io_debouncer #(.WIDTH(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_db (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .raw_i   (key_n),
    .db_o    (key_db),
    .event_o (key_ev)
  );

  io_debouncer #(.WIDTH(10), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .raw_i   (SW),
    .db_o    (sw_db),
    .event_o (sw_ev)
  );

  logic hit_kdata, hit_kctrl, hit_sdata, hit_sctrl;
  logic k_rd, k_wr, s_rd, s_wr;

  assign hit_kdata = (ADDRIN == ADDRKEY);
  assign hit_kctrl = (ADDRIN == ADDRKCTRL);
  assign hit_sdata = (ADDRIN == ADDRSW);
  assign hit_sctrl = (ADDRIN == ADDRSCTRL);
  assign k_rd      = RE & hit_kdata;
  assign k_wr      = WE & hit_kctrl;
  assign s_rd      = RE & hit_sdata;
  assign s_wr      = WE & hit_sctrl;

  logic kready_q, kready_d, kovr_q, kovr_d, kie_q, kie_d;
  logic sready_q, sready_d, sovr_q, sovr_d, sie_q, sie_d;
  logic irq_q, irq_d;

  always_comb begin
    kready_d = kready_q;
    kovr_d   = kovr_q;
    kie_d    = kie_q;
    sready_d = sready_q;
    sovr_d   = sovr_q;
    sie_d    = sie_q;

    // A new event outranks a same-cycle data read and does not count as an overrun
    if (key_ev)    kready_d = 1'b1;
    else if (k_rd) kready_d = 1'b0;
    if (key_ev && kready_q && !k_rd)     kovr_d = 1'b1;
    else if (k_wr && !DIN[CTRL_OVERRUN]) kovr_d = 1'b0;
    if (k_wr) kie_d = DIN[CTRL_IE];

    if (sw_ev)     sready_d = 1'b1;
    else if (s_rd) sready_d = 1'b0;
    if (sw_ev && sready_q && !s_rd)      sovr_d = 1'b1;
    else if (s_wr && !DIN[CTRL_OVERRUN]) sovr_d = 1'b0;
    if (s_wr) sie_d = DIN[CTRL_IE];

    irq_d = (kready_q & kie_q) | (sready_q & sie_q);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      kready_q <= 1'b0;
      kovr_q   <= 1'b0;
      kie_q    <= 1'b0;
      sready_q <= 1'b0;
      sovr_q   <= 1'b0;
      sie_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      kready_q <= kready_d;
      kovr_q   <= kovr_d;
      kie_q    <= kie_d;
      sready_q <= sready_d;
      sovr_q   <= sovr_d;
      sie_q    <= sie_d;
      irq_q    <= irq_d;
    end
  end

  always_comb begin
    DOUT = '0;
    if (hit_kdata)      DOUT = {28'b0, key_db};
    else if (hit_kctrl) DOUT = ctrl_word(kie_q, kovr_q, kready_q);
    else if (hit_sdata) DOUT = {22'b0, sw_db};
    else if (hit_sctrl) DOUT = ctrl_word(sie_q, sovr_q, sready_q);
  end

  assign SEL = hit_kdata | hit_kctrl | hit_sdata | hit_sctrl;
  assign IRQ = irq_q;

  logic unused_din;
  assign unused_din = ^{DIN[31:9], DIN[7:3], DIN[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_io_input_ctrl.sv
// ============================================================================
// tb_io_input_ctrl: scoreboard bench with a window-based reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_io_input_ctrl;
  import io_defs::*;

  localparam int N = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  KEY;
  logic [9:0]  SW;
  logic [31:0] ADDRIN, DIN;
  logic        WE, RE;
  logic [31:0] DOUT;
  logic        SEL, IRQ;

  always #5 CLK = ~CLK;

  io_input_ctrl #(.DEBOUNCE_CYCLES(N)) dut (
    .CLK(CLK), .RESET(RESET), .KEY(KEY), .SW(SW), .ADDRIN(ADDRIN), .DIN(DIN),
    .WE(WE), .RE(RE), .DOUT(DOUT), .SEL(SEL), .IRQ(IRQ)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] dout;
    logic        sel;
    logic        irq;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   probe    = 1'b0;

  // Reference model: pin history per cycle; the synchronized value lags the pin by two cycles
  logic [3:0] kh [N+2];
  logic [9:0] sh [N+2];
  logic [3:0] m_kdb;
  logic [9:0] m_sdb;
  logic m_krdy, m_kovr, m_kie, m_srdy, m_sovr, m_sie, m_irq;

  function automatic bit k_accept();
    for (int i = 3; i <= N + 1; i++) if (kh[i] !== kh[2]) return 1'b0;
    return kh[2] !== m_kdb;
  endfunction

  function automatic bit s_accept();
    for (int i = 3; i <= N + 1; i++) if (sh[i] !== sh[2]) return 1'b0;
    return sh[2] !== m_sdb;
  endfunction

  task automatic grp(input bit ev, input bit rd, input bit wr, input logic [31:0] d,
                     inout logic rdy, inout logic ovr, inout logic ie);
    bit set_ovr;
    set_ovr = ev && rdy && !rd;
    if (ev) rdy = 1'b1;
    else if (rd) rdy = 1'b0;
    if (set_ovr) ovr = 1'b1;
    else if (wr && !d[2]) ovr = 1'b0;
    if (wr) ie = d[8];
  endtask

  task automatic model_step();
    bit kev, sev;
    logic nirq;
    if (RESET) begin
      for (int i = 0; i < N + 2; i++) begin kh[i] = '0; sh[i] = '0; end
      m_kdb = '0; m_sdb = '0;
      {m_krdy, m_kovr, m_kie, m_srdy, m_sovr, m_sie, m_irq} = '0;
      return;
    end
    nirq = (m_krdy & m_kie) | (m_srdy & m_sie);
    for (int i = N + 1; i > 0; i--) begin kh[i] = kh[i-1]; sh[i] = sh[i-1]; end
    kh[0] = ~KEY;
    sh[0] = SW;
    kev = k_accept();
    sev = s_accept();
    if (kev) m_kdb = kh[2];
    if (sev) m_sdb = sh[2];
    grp(kev, RE && ADDRIN == KEY_DATA_ADDR, WE && ADDRIN == KEY_CTRL_ADDR, DIN, m_krdy, m_kovr, m_kie);
    grp(sev, RE && ADDRIN == SW_DATA_ADDR,  WE && ADDRIN == SW_CTRL_ADDR,  DIN, m_srdy, m_sovr, m_sie);
    m_irq = nirq;
  endtask

  function automatic exp_t model_read(input logic [31:0] a);
    exp_t e;
    e.addr = a; e.irq = m_irq; e.sel = 1'b1;
    case (a)
      KEY_DATA_ADDR: e.dout = {28'b0, m_kdb};
      KEY_CTRL_ADDR: e.dout = {23'b0, m_kie, 5'b0, m_kovr, 1'b0, m_krdy};
      SW_DATA_ADDR:  e.dout = {22'b0, m_sdb};
      SW_CTRL_ADDR:  e.dout = {23'b0, m_sie, 5'b0, m_sovr, 1'b0, m_srdy};
      default: begin e.dout = '0; e.sel = 1'b0; end
    endcase
    return e;
  endfunction

  task automatic drive(input logic [31:0] a, input logic re, input logic we, input logic [31:0] d,
                       input bit fx, input logic [31:0] fd, input logic fs, input logic fi);
    exp_t e;
    ADDRIN = a; RE = re; WE = we; DIN = d;
    if (fx) begin e.addr = a; e.dout = fd; e.sel = fs; e.irq = fi; end
    else e = model_read(a);
    q.push_back(e);
    probe = 1'b1;
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic step(input logic [31:0] a, input logic re, input logic we, input logic [31:0] d);
    drive(a, re, we, d, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic fixed(input logic [31:0] a, input logic re, input logic [31:0] fd, input logic fi);
    drive(a, re, 1'b0, '0, 1'b1, fd, 1'b1, fi);
  endtask

  task automatic idle(input int n, input logic [31:0] a);
    for (int i = 0; i < n; i++) step(a, 1'b0, 1'b0, '0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (probe) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard: DUT output with no expectation queued");
        end else begin
          e = q.pop_front();
          if (DOUT !== e.dout || SEL !== e.sel || IRQ !== e.irq) begin
            n_fail++;
            $display("FAIL read %h: got DOUT=%h SEL=%b IRQ=%b, expected DOUT=%h SEL=%b IRQ=%b",
                     e.addr, DOUT, SEL, IRQ, e.dout, e.sel, e.irq);
          end
        end
      end
    end
  end

  logic [31:0] addr_tab [5];
  int khold, shold;

  initial begin : stim
    addr_tab[0] = KEY_DATA_ADDR; addr_tab[1] = KEY_CTRL_ADDR;
    addr_tab[2] = SW_DATA_ADDR;  addr_tab[3] = SW_CTRL_ADDR;
    addr_tab[4] = 32'hF000_0018;
    RESET = 1'b1; KEY = 4'hF; SW = '0; ADDRIN = '0; DIN = '0; WE = 1'b0; RE = 1'b0;
    @(posedge CLK); model_step(); #1;
    fixed(KEY_DATA_ADDR, 1'b0, 32'h0, 1'b0);
    RESET = 1'b0;

    // Reset values on all four registers and an unmatched address
    fixed(KEY_DATA_ADDR, 1'b1, 32'h0, 1'b0);
    fixed(KEY_CTRL_ADDR, 1'b1, 32'h0, 1'b0);
    fixed(SW_DATA_ADDR,  1'b1, 32'h0, 1'b0);
    fixed(SW_CTRL_ADDR,  1'b1, 32'h0, 1'b0);
    drive(32'hF000_0018, 1'b1, 1'b0, '0, 1'b1, 32'h0, 1'b0, 1'b0);

    // Key press: visible DEBOUNCE_CYCLES+2 cycles after the pin change
    KEY = 4'b1110;
    for (int i = 0; i < N + 2; i++) fixed(KEY_DATA_ADDR, 1'b0, 32'h0, 1'b0);
    fixed(KEY_DATA_ADDR, 1'b0, 32'h1, 1'b0);
    fixed(KEY_CTRL_ADDR, 1'b0, 32'h1, 1'b0);
    fixed(KEY_DATA_ADDR, 1'b1, 32'h1, 1'b0);
    fixed(KEY_CTRL_ADDR, 1'b0, 32'h0, 1'b0);

    // Short glitch never gets through
    SW = 10'h008;
    for (int i = 0; i < 3; i++) fixed(SW_DATA_ADDR, 1'b0, 32'h0, 1'b0);
    SW = 10'h000;
    for (int i = 0; i < 20; i++) fixed((i % 2) ? SW_CTRL_ADDR : SW_DATA_ADDR, 1'b0, 32'h0, 1'b0);

    // Overrun and its write-to-clear semantics
    SW = 10'h001; idle(8, SW_DATA_ADDR);
    SW = 10'h003; idle(8, SW_DATA_ADDR);
    fixed(SW_CTRL_ADDR, 1'b0, 32'h5, 1'b0);
    step(SW_CTRL_ADDR, 1'b0, 1'b1, 32'h0);
    fixed(SW_CTRL_ADDR, 1'b0, 32'h1, 1'b0);
    SW = 10'h007; idle(8, SW_CTRL_ADDR);
    fixed(SW_CTRL_ADDR, 1'b0, 32'h5, 1'b0);
    step(SW_CTRL_ADDR, 1'b0, 1'b1, 32'h4);
    fixed(SW_CTRL_ADDR, 1'b0, 32'h5, 1'b0);
    fixed(SW_DATA_ADDR, 1'b1, 32'h7, 1'b0);
    fixed(SW_CTRL_ADDR, 1'b0, 32'h4, 1'b0);
    step(SW_CTRL_ADDR, 1'b0, 1'b1, 32'h0);
    fixed(SW_CTRL_ADDR, 1'b0, 32'h0, 1'b0);

    // Interrupt enable, release event, read clears
    step(KEY_CTRL_ADDR, 1'b0, 1'b1, 32'h100);
    KEY = 4'hF; idle(10, KEY_CTRL_ADDR);
    step(KEY_DATA_ADDR, 1'b1, 1'b0, '0);
    idle(3, KEY_CTRL_ADDR);

    // Data read in the same cycle as a new event
    KEY = 4'b1110; idle(8, KEY_CTRL_ADDR);
    KEY = 4'hF; idle(5, KEY_CTRL_ADDR);
    step(KEY_DATA_ADDR, 1'b1, 1'b0, '0);
    fixed(KEY_CTRL_ADDR, 1'b0, 32'h101, 1'b1);

    // Reset in the middle of a debounce window
    SW = 10'h000; idle(3, SW_DATA_ADDR);
    RESET = 1'b1; step(SW_CTRL_ADDR, 1'b0, 1'b0, '0); RESET = 1'b0;
    fixed(SW_CTRL_ADDR, 1'b0, 32'h0, 1'b0);
    fixed(KEY_CTRL_ADDR, 1'b0, 32'h0, 1'b0);
    idle(8, SW_DATA_ADDR);
    SW = 10'h001;
    RESET = 1'b1; step(SW_CTRL_ADDR, 1'b0, 1'b0, '0); RESET = 1'b0;
    for (int i = 0; i < N + 2; i++) fixed(SW_CTRL_ADDR, 1'b0, 32'h0, 1'b0);
    fixed(SW_CTRL_ADDR, 1'b0, 32'h1, 1'b0);

    // Randomized traffic against the model
    khold = 0; shold = 0;
    for (int c = 0; c < 600; c++) begin
      if (khold == 0) begin KEY = 4'($urandom); khold = $urandom_range(1, 9); end
      if (shold == 0) begin SW = 10'($urandom); shold = $urandom_range(1, 9); end
      khold--; shold--;
      RESET = ($urandom_range(0, 199) == 0);
      step(addr_tab[$urandom_range(0, 4)], $urandom_range(0, 3) == 0,
           $urandom_range(0, 4) == 0, $urandom);
    end
    RESET = 1'b0;

    probe = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
